// File: rtl/bch_encoder_15_5.sv
// Systematic BCH(15,5) encoder, g(x) = x^10+x^8+x^5+x^4+x^2+x+1 (0x537), t = 3.
// Default: serial 5-cycle LFSR division. Define BCH_ENC_PARALLEL_EN for single-step XOR-tree parity.
module bch_encoder_15_5 (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [4:0]  data_in,
  output logic [14:0] codeword,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t     state;
  logic [4:0] msg;

`ifdef BCH_ENC_PARALLEL_EN

  // Remainders x^(10+i) mod g(x); parity is the XOR of the rows selected by message bits.
  localparam logic [9:0] REM_X10 = 10'h137;
  localparam logic [9:0] REM_X11 = 10'h26E;
  localparam logic [9:0] REM_X12 = 10'h1EB;
  localparam logic [9:0] REM_X13 = 10'h3D6;
  localparam logic [9:0] REM_X14 = 10'h29B;

  logic [9:0] parity;

  always_comb begin
    parity = ({10{msg[0]}} & REM_X10)
           ^ ({10{msg[1]}} & REM_X11)
           ^ ({10{msg[2]}} & REM_X12)
           ^ ({10{msg[3]}} & REM_X13)
           ^ ({10{msg[4]}} & REM_X14);
  end

  // NOTE: every register is cleared by the asynchronous reset, and state updates use <= only
  // so all flops in this block see the pre-edge values of each other.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      msg      <= '0;
      codeword <= '0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            msg   <= data_in;
            state <= DONE;
          end
        end
        DONE: begin
          codeword <= {msg, parity};
          done     <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`else

  localparam logic [9:0] G_LOW = 10'h137;

  logic [9:0] lfsr;
  logic [2:0] cnt;
  logic       msg_bit;
  logic       fb;
  logic [9:0] lfsr_next;

  // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
  always_comb begin
    msg_bit   = msg[3'd4 - cnt];
    fb        = msg_bit ^ lfsr[9];
    lfsr_next = {lfsr[8:0], 1'b0} ^ (fb ? G_LOW : 10'h000);
  end

  // NOTE: every register is cleared by the asynchronous reset, and state updates use <= only
  // so all flops in this block see the pre-edge values of each other.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      msg      <= '0;
      lfsr     <= '0;
      cnt      <= '0;
      codeword <= '0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            msg   <= data_in;
            lfsr  <= '0;
            cnt   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          lfsr <= lfsr_next;
          cnt  <= cnt + 3'd1;
          if (cnt == 3'd4) begin
            codeword <= {msg, lfsr_next};
            done     <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          // The edge leaving DONE is E6 of the previous encode, which may already start the next one.
          done <= 1'b0;
          if (start) begin
            msg   <= data_in;
            lfsr  <= '0;
            cnt   <= '0;
            state <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`endif

endmodule

// File: tb/tb_bch_encoder_15_5.sv
// Self-checking bench for bch_encoder_15_5: scoreboard of expected codewords against a
// polynomial long-division model, plus code-property checks over all 32 messages.
module tb_bch_encoder_15_5;

  logic        clk;
  logic        rst;
  logic        start;
  logic [4:0]  data_in;
  logic [14:0] codeword;
  logic        done;

  int n_assert = 0;
  int n_fail   = 0;

  logic [14:0] exp_q[$];
  logic [14:0] all_cw[32];

`ifdef BCH_ENC_PARALLEL_EN
  localparam int LAT_EXP  = 1;
  localparam int HELD_EXP = 6;
`else
  localparam int LAT_EXP  = 5;
  localparam int HELD_EXP = 2;
`endif

  bch_encoder_15_5 dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .data_in  (data_in),
    .codeword (codeword),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [9:0] poly_rem(input logic [14:0] c);
    logic [14:0] r;
    r = c;
    for (int i = 14; i >= 10; i--) begin
      if (r[i]) r = r ^ (15'h537 << (i - 10));
    end
    return r[9:0];
  endfunction

  function automatic logic [14:0] bch_model(input logic [4:0] m);
    return {m, poly_rem({m, 10'b0})};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One encode: start at E0, scramble data_in afterwards, wait (bounded) for done.
  task automatic encode(input logic [4:0] m, input string tag);
    int lat;
    logic [14:0] exp_cw;
    data_in = m;
    start   = 1'b1;
    exp_q.push_back(bch_model(m));
    tick();
    start   = 1'b0;
    data_in = ~m;
    lat = 0;
    while (!done && lat < 20) begin
      tick();
      lat++;
    end
    exp_cw = exp_q.pop_front();
    check({tag, "_done_seen"}, 32'(done), 32'd1);
    check({tag, "_latency"}, 32'(lat), 32'(LAT_EXP));
    check({tag, "_codeword"}, 32'(codeword), 32'(exp_cw));
    tick();
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    int dcount;
    int min_dist;
    int w;

    rst     = 1'b0;
    start   = 1'b1;
    data_in = 5'b10101;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("reset_codeword", 32'(codeword), 32'd0);
      check("reset_done", 32'(done), 32'd0);
    end
    rst   = 1'b1;
    start = 1'b0;

    // First edge after release is usable.
    encode(5'b10101, "first_after_reset");
    check("lit_10101", 32'(codeword), 32'h5647);
    encode(5'b00001, "m00001");
    check("lit_00001", 32'(codeword), 32'h0537);
    encode(5'b00000, "m00000");
    check("lit_00000", 32'(codeword), 32'h0000);
    encode(5'b11111, "m11111");
    check("lit_11111", 32'(codeword), 32'h7FFF);

    for (int m = 0; m < 32; m++) begin
      encode(5'(m), "sweep");
      all_cw[m] = codeword;
      check("sweep_prefix", 32'(codeword[14:10]), 32'(m));
      check("sweep_syndrome", 32'(poly_rem(codeword)), 32'd0);
      if (m != 0) begin
        w = $countones(codeword);
        check("sweep_weight", 32'((w == 7) || (w == 8) || (w == 15)), 32'd1);
      end
    end
    min_dist = 15;
    for (int a = 0; a < 32; a++) begin
      for (int b = a + 1; b < 32; b++) begin
        if ($countones(all_cw[a] ^ all_cw[b]) < min_dist) min_dist = $countones(all_cw[a] ^ all_cw[b]);
      end
    end
    check("min_distance", 32'(min_dist), 32'd7);

`ifndef BCH_ENC_PARALLEL_EN
    // start pulsed mid-SHIFT with different data must be ignored.
    data_in = 5'b10101;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    data_in = 5'b01010;
    tick();
    start   = 1'b1;
    data_in = 5'b00001;
    tick();
    start   = 1'b0;
    dcount  = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) dcount++;
      tick();
    end
    check("shift_start_done_count", 32'(dcount), 32'd1);
    check("shift_start_codeword", 32'(codeword), 32'h5647);
`endif

    // start held high: a new encode begins as soon as the FSM can accept it.
    data_in = 5'b00001;
    start   = 1'b1;
    tick();
    dcount = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (done) dcount++;
      if (i == 11) start = 1'b0;
    end
    check("held_start_done_count", 32'(dcount), 32'(HELD_EXP));
    check("held_start_codeword", 32'(codeword), 32'h0537);
    for (int i = 0; i < 8; i++) tick();

    // Reset just after E3 aborts the encode.
    data_in = 5'b11111;
    start   = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("abort_codeword", 32'(codeword), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    tick();
    rst    = 1'b1;
    dcount = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done) dcount++;
    end
    check("abort_no_done", 32'(dcount), 32'd0);
    check("abort_codeword_held", 32'(codeword), 32'd0);

    encode(5'b10101, "after_abort");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
